// File: rtl/pcm_mem_pkg.sv
// Shared widths, FSM state type and byte-lane helpers for the pcm_mem_mm responder.
package pcm_mem_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;
  localparam int BE_W   = 2;
  localparam int CNT_W  = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } pcm_mem_state_t;

  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_word,
                                                   input logic [DATA_W-1:0] new_word,
                                                   input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] res;
    for (int i = 0; i < BE_W; i++) begin
      res[i*8 +: 8] = be[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
    end
    return res;
  endfunction

  // Even parity per lane: the stored bit makes byte plus bit hold an even count of ones.
  function automatic logic [BE_W-1:0] lane_parity(input logic [DATA_W-1:0] word);
    logic [BE_W-1:0] p;
    for (int i = 0; i < BE_W; i++) begin
      p[i] = ^word[i*8 +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/pcm_mem_rd_pipe.sv
// Clken-gated valid/data shift register; the last stage strobes the readdata update.
module pcm_mem_rd_pipe #(
  parameter int LATENCY = 1,
  parameter int W       = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clken,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [LATENCY-1:0] valid_r;
  logic [W-1:0]       data_r [LATENCY];

  // Shift read requests one stage per enabled clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= '0;
      for (int i = 0; i < LATENCY; i++) data_r[i] <= '0;
    end else if (clken) begin
      valid_r[0] <= in_valid;
      data_r[0]  <= in_data;
      for (int i = 1; i < LATENCY; i++) begin
        valid_r[i] <= valid_r[i-1];
        data_r[i]  <= data_r[i-1];
      end
    end
  end

  assign out_valid = valid_r[LATENCY-1];
  assign out_data  = data_r[LATENCY-1];

endmodule

// File: rtl/pcm_mem_mm_slave.sv
// Word-addressed memory responder with clear sweep and saturating access counters.
// Optional per-lane parity storage and checking with PCM_MEM_PARITY_EN.
module pcm_mem_mm_slave
  import pcm_mem_pkg::*;
#(
  parameter int DEPTH        = 2048,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [ADDR_W-1:0] pcm_mem_mm_address,
  input  logic              pcm_mem_mm_chipselect,
  input  logic              pcm_mem_mm_clken,
  input  logic              pcm_mem_mm_write,
  input  logic [DATA_W-1:0] pcm_mem_mm_writedata,
  input  logic [BE_W-1:0]   pcm_mem_mm_byteenable,
  output logic [DATA_W-1:0] pcm_mem_mm_readdata,
  output logic              busy,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count
`ifdef PCM_MEM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

`ifdef PCM_MEM_PARITY_EN
  localparam int PIPE_W = DATA_W + BE_W;
`else
  localparam int PIPE_W = DATA_W;
`endif
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  pcm_mem_state_t    state_r, state_nxt_s;
  logic [ADDR_W-1:0] clr_addr_r, clr_addr_nxt_s;
  logic              busy_r, busy_nxt_s, cnt_clr_s;
  logic              accept_s, wr_accept_s, rd_accept_s, in_range_s;
  logic [CNT_W-1:0]  wr_count_r, rd_count_r;
  logic [DATA_W-1:0] readdata_r, rd_word_s;
  logic [PIPE_W-1:0] pipe_in_s, pipe_out_s;
  logic              pipe_valid_s;
  logic [DATA_W-1:0] mem_r [DEPTH];

  // Next-state logic: init always (re)starts the sweep at word 0.
  always_comb begin
    state_nxt_s    = state_r;
    clr_addr_nxt_s = clr_addr_r;
    busy_nxt_s     = busy_r;
    cnt_clr_s      = 1'b0;
    if (init) begin
      state_nxt_s    = CLEAR;
      clr_addr_nxt_s = '0;
      busy_nxt_s     = 1'b1;
      cnt_clr_s      = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = IDLE;
        end
        CLEAR: begin
          if (clr_addr_r == LAST_ADDR) begin
            state_nxt_s = IDLE;
            busy_nxt_s  = 1'b0;
          end else begin
            clr_addr_nxt_s = clr_addr_r + 1'b1;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          busy_nxt_s  = 1'b0;
        end
      endcase
    end
  end

  // FSM state register, frozen while clken is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      clr_addr_r <= '0;
      busy_r     <= 1'b0;
    end else if (pcm_mem_mm_clken) begin
      state_r    <= state_nxt_s;
      clr_addr_r <= clr_addr_nxt_s;
      busy_r     <= busy_nxt_s;
    end
  end

  assign accept_s    = pcm_mem_mm_chipselect & (state_r == IDLE) & ~init;
  assign wr_accept_s = accept_s & pcm_mem_mm_write;
  assign rd_accept_s = accept_s & ~pcm_mem_mm_write;
  assign in_range_s  = ({1'b0, pcm_mem_mm_address} < DEPTH_W);
  assign rd_word_s   = in_range_s ? mem_r[pcm_mem_mm_address] : '0;

  // Array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (pcm_mem_mm_clken) begin
      if (state_r == CLEAR) begin
        mem_r[clr_addr_r] <= '0;
      end else if (wr_accept_s && in_range_s) begin
        mem_r[pcm_mem_mm_address] <= byte_merge(mem_r[pcm_mem_mm_address],
                                                pcm_mem_mm_writedata, pcm_mem_mm_byteenable);
      end
    end
  end

`ifdef PCM_MEM_PARITY_EN
  logic [BE_W-1:0] par_mem_r [DEPTH];
  logic            parity_err_r;

  // Parity bits follow the same lane enables as the data they protect.
  always_ff @(posedge clk) begin
    if (pcm_mem_mm_clken) begin
      if (state_r == CLEAR) begin
        par_mem_r[clr_addr_r] <= '0;
      end else if (wr_accept_s && in_range_s) begin
        par_mem_r[pcm_mem_mm_address] <= (par_mem_r[pcm_mem_mm_address] & ~pcm_mem_mm_byteenable)
                                       | (lane_parity(pcm_mem_mm_writedata) & pcm_mem_mm_byteenable);
      end
    end
  end

  assign pipe_in_s  = {(in_range_s ? par_mem_r[pcm_mem_mm_address] : 2'b00), rd_word_s};
  assign parity_err = parity_err_r;
`else
  assign pipe_in_s  = rd_word_s;
`endif

  pcm_mem_rd_pipe #(
    .LATENCY (READ_LATENCY),
    .W       (PIPE_W)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .clken     (pcm_mem_mm_clken),
    .in_valid  (rd_accept_s),
    .in_data   (pipe_in_s),
    .out_valid (pipe_valid_s),
    .out_data  (pipe_out_s)
  );

  // Readdata (and parity flag) update only on a pipeline return strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_r   <= '0;
`ifdef PCM_MEM_PARITY_EN
      parity_err_r <= 1'b0;
`endif
    end else if (pcm_mem_mm_clken && pipe_valid_s) begin
      readdata_r   <= pipe_out_s[DATA_W-1:0];
`ifdef PCM_MEM_PARITY_EN
      parity_err_r <= |(lane_parity(pipe_out_s[DATA_W-1:0]) ^ pipe_out_s[PIPE_W-1:DATA_W]);
`endif
    end
  end

  // Saturating access counters, cleared when a sweep starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_count_r <= '0;
      rd_count_r <= '0;
    end else if (pcm_mem_mm_clken) begin
      if (cnt_clr_s) begin
        wr_count_r <= '0;
        rd_count_r <= '0;
      end else begin
        if (wr_accept_s && (wr_count_r != 16'hFFFF)) wr_count_r <= wr_count_r + 16'd1;
        if (rd_accept_s && (rd_count_r != 16'hFFFF)) rd_count_r <= rd_count_r + 16'd1;
      end
    end
  end

  assign pcm_mem_mm_readdata = readdata_r;
  assign busy                = busy_r;
  assign wr_count            = wr_count_r;
  assign rd_count            = rd_count_r;

endmodule

// File: tb/tb_pcm_mem_mm_slave.sv
// Directed self-checking bench: a DEPTH=2048 instance plus a DEPTH=1024 instance on shared stimulus.
module tb_pcm_mem_mm_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, init, cs, clken, wr;
  logic [10:0] addr;
  logic [15:0] wdata;
  logic [1:0]  be;
  logic [15:0] rdata, rdata2, wrc, wrc2, rdc, rdc2;
  logic        busy, busy2;
`ifdef PCM_MEM_PARITY_EN
  logic        perr, perr2;
`endif
  int errors = 0;
  int checks = 0;

  pcm_mem_mm_slave #(.DEPTH(2048), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .init(init), .pcm_mem_mm_address(addr),
    .pcm_mem_mm_chipselect(cs), .pcm_mem_mm_clken(clken), .pcm_mem_mm_write(wr),
    .pcm_mem_mm_writedata(wdata), .pcm_mem_mm_byteenable(be), .pcm_mem_mm_readdata(rdata),
    .busy(busy), .wr_count(wrc), .rd_count(rdc)
`ifdef PCM_MEM_PARITY_EN
    , .parity_err(perr)
`endif
  );

  pcm_mem_mm_slave #(.DEPTH(1024), .READ_LATENCY(1)) dut2 (
    .clk(clk), .reset(reset), .init(init), .pcm_mem_mm_address(addr),
    .pcm_mem_mm_chipselect(cs), .pcm_mem_mm_clken(clken), .pcm_mem_mm_write(wr),
    .pcm_mem_mm_writedata(wdata), .pcm_mem_mm_byteenable(be), .pcm_mem_mm_readdata(rdata2),
    .busy(busy2), .wr_count(wrc2), .rd_count(rdc2)
`ifdef PCM_MEM_PARITY_EN
    , .parity_err(perr2)
`endif
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [10:0] a, input logic [15:0] d, input logic [1:0] b);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d; be = b;
    cycle();
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [10:0] a);
    cs = 1'b1; wr = 1'b0; addr = a;
    cycle();
    cs = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; init = 1'b0; cs = 1'b0; clken = 1'b1; wr = 1'b0;
    addr = 11'd0; wdata = 16'h0000; be = 2'b11;
    cycle(); cycle();
    reset = 1'b0;
    cycle();
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_readdata got=%h exp=0000", rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (wrc !== 16'h0000 || rdc !== 16'h0000) begin errors++; $display("FAIL reset_counts got=%h/%h exp=0000/0000", wrc, rdc); end
  endtask

  task automatic test_basic_rw();
    bus_write(11'h005, 16'hBEEF, 2'b11);
    bus_read(11'h005);
    cycle();
    checks++; if (rdata !== 16'hBEEF) begin errors++; $display("FAIL basic_read got=%h exp=BEEF", rdata); end
    checks++; if (wrc !== 16'd1 || rdc !== 16'd1) begin errors++; $display("FAIL basic_counts got=%0d/%0d exp=1/1", wrc, rdc); end
  endtask

  task automatic test_byte_lanes();
    bus_write(11'h010, 16'h1234, 2'b11);
    bus_write(11'h010, 16'hFFAB, 2'b01);
    bus_read(11'h010);
    cycle();
    checks++; if (rdata !== 16'h12AB) begin errors++; $display("FAIL lane_merge got=%h exp=12AB", rdata); end
    checks++; if (wrc !== 16'd3 || rdc !== 16'd2) begin errors++; $display("FAIL lane_counts got=%0d/%0d exp=3/2", wrc, rdc); end
  endtask

  task automatic test_clear_sweep();
    int n;
    int guard;
    init = 1'b1;
    cycle();
    init = 1'b0;
    n = busy ? 1 : 0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sweep_busy_start got=%b exp=1", busy); end
    checks++; if (wrc !== 16'd0 || rdc !== 16'd0) begin errors++; $display("FAIL sweep_cnt_clr got=%0d/%0d exp=0/0", wrc, rdc); end
    bus_write(11'h005, 16'hDEAD, 2'b11);
    if (busy) n++;
    bus_read(11'h010);
    if (busy) n++;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (busy) n++;
    end
    checks++; if (rdata !== 16'h12AB) begin errors++; $display("FAIL sweep_read_dropped got=%h exp=12AB", rdata); end
    checks++; if (wrc !== 16'd0 || rdc !== 16'd0) begin errors++; $display("FAIL sweep_cnt_frozen got=%0d/%0d exp=0/0", wrc, rdc); end
    guard = 0;
    while (busy && guard < 5000) begin
      cycle();
      guard++;
      if (busy) n++;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sweep_timeout busy=%b exp=0", busy); end
    checks++; if (n !== 2048) begin errors++; $display("FAIL sweep_length got=%0d exp=2048", n); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL sweep2_done got=%b exp=0", busy2); end
    bus_read(11'h005);
    cycle();
    checks++; if (rdata !== 16'h0000 || rdata2 !== 16'h0000) begin errors++; $display("FAIL sweep_cleared got=%h/%h exp=0000/0000", rdata, rdata2); end
    checks++; if (wrc !== 16'd0 || rdc !== 16'd1) begin errors++; $display("FAIL sweep_post_counts got=%0d/%0d exp=0/1", wrc, rdc); end
  endtask

  task automatic test_back_to_back_stall();
    bus_write(11'h001, 16'h1111, 2'b11);
    bus_write(11'h002, 16'h2222, 2'b11);
    bus_write(11'h003, 16'h3333, 2'b11);
    cs = 1'b1; wr = 1'b0; addr = 11'h001;
    cycle();
    addr = 11'h002;
    cycle();
    checks++; if (rdata !== 16'h1111) begin errors++; $display("FAIL b2b_first got=%h exp=1111", rdata); end
    addr = 11'h003; clken = 1'b0;
    cycle();
    checks++; if (rdata !== 16'h1111) begin errors++; $display("FAIL stall_hold1 got=%h exp=1111", rdata); end
    cycle();
    checks++; if (rdata !== 16'h1111 || rdc !== 16'd3) begin errors++; $display("FAIL stall_hold2 got=%h/%0d exp=1111/3", rdata, rdc); end
    clken = 1'b1;
    cycle();
    cs = 1'b0;
    checks++; if (rdata !== 16'h2222) begin errors++; $display("FAIL b2b_second got=%h exp=2222", rdata); end
    cycle();
    checks++; if (rdata !== 16'h3333) begin errors++; $display("FAIL b2b_third got=%h exp=3333", rdata); end
    checks++; if (wrc !== 16'd3 || rdc !== 16'd4) begin errors++; $display("FAIL b2b_counts got=%0d/%0d exp=3/4", wrc, rdc); end
  endtask

  task automatic test_depth_bound();
    bus_write(11'h000, 16'h5A5A, 2'b11);
    bus_write(11'h400, 16'hAAAA, 2'b11);
    bus_read(11'h400);
    cycle();
    checks++; if (rdata !== 16'hAAAA) begin errors++; $display("FAIL backed_400 got=%h exp=AAAA", rdata); end
    checks++; if (rdata2 !== 16'h0000) begin errors++; $display("FAIL unbacked_400 got=%h exp=0000", rdata2); end
    bus_write(11'h000, 16'hFFFF, 2'b00);
    bus_read(11'h000);
    cycle();
    checks++; if (rdata2 !== 16'h5A5A || rdata !== 16'h5A5A) begin errors++; $display("FAIL no_alias_be00 got=%h/%h exp=5A5A/5A5A", rdata, rdata2); end
    checks++; if (wrc2 !== 16'd6 || rdc2 !== 16'd6) begin errors++; $display("FAIL depth_counts got=%0d/%0d exp=6/6", wrc2, rdc2); end
  endtask

  task automatic test_reset_mid_sweep();
    init = 1'b1;
    cycle();
    init = 1'b0;
    repeat (10) cycle();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midsweep_busy got=%b exp=1", busy); end
    reset = 1'b1;
    #2;
    checks++; if (busy !== 1'b0 || rdata !== 16'h0000) begin errors++; $display("FAIL async_reset got=%b/%h exp=0/0000", busy, rdata); end
    reset = 1'b0;
    cycle();
    bus_read(11'h400);
    cycle();
    checks++; if (rdata !== 16'hAAAA || busy !== 1'b0) begin errors++; $display("FAIL partial_keep got=%h/%b exp=AAAA/0", rdata, busy); end
    bus_read(11'h000);
    cycle();
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL partial_clear got=%h exp=0000", rdata); end
  endtask

`ifdef PCM_MEM_PARITY_EN
  task automatic test_parity();
    bus_write(11'h020, 16'h0301, 2'b11);
    bus_read(11'h020);
    cycle();
    checks++; if (perr !== 1'b0 || rdata !== 16'h0301) begin errors++; $display("FAIL parity_clean got=%b/%h exp=0/0301", perr, rdata); end
    dut.par_mem_r[32] = dut.par_mem_r[32] ^ 2'b01;
    bus_read(11'h020);
    cycle();
    checks++; if (perr !== 1'b1) begin errors++; $display("FAIL parity_flip got=%b exp=1", perr); end
    bus_read(11'h400);
    cycle();
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL parity_recover got=%b exp=0", perr); end
  endtask
`endif

  task automatic test_saturate();
    cs = 1'b1; wr = 1'b1; addr = 11'h007; wdata = 16'h0000; be = 2'b11;
    repeat (65535) cycle();
    checks++; if (wrc !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got=%h exp=FFFF", wrc); end
    repeat (5) cycle();
    cs = 1'b0; wr = 1'b0;
    checks++; if (wrc !== 16'hFFFF || wrc2 !== 16'hFFFF) begin errors++; $display("FAIL sat_stick got=%h/%h exp=FFFF/FFFF", wrc, wrc2); end
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_byte_lanes();
    test_clear_sweep();
    test_back_to_back_stall();
    test_depth_bound();
    test_reset_mid_sweep();
`ifdef PCM_MEM_PARITY_EN
    test_parity();
`endif
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
